// File: rtl/stream_pkg.sv
// Shared width constant and word type for the stream fork/join blocks.
package stream_pkg;
  localparam int unsigned DEFAULT_DATA_W = 9;
  typedef logic [DEFAULT_DATA_W-1:0] data_t;
endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry head/tail buffer with push/pop handshakes and a registered ready.
module stream_skid_buf
  import stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              ready,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid
);

  logic [1:0]        occ;
  logic [1:0]        occ_next;
  logic [DATA_W-1:0] tail_data;
  logic              push_ok;
  logic              pop_ok;

  assign head_valid = (occ != 2'd0);
  assign push_ok    = push & ready;
  assign pop_ok     = pop & head_valid;

  always_comb begin
    occ_next = occ;
    if (push_ok && !pop_ok)
      occ_next = occ + 2'd1;
    else if (!push_ok && pop_ok)
      occ_next = occ - 2'd1;
  end

  // ready looks at next-state occupancy so it can be a plain flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= '0;
      ready <= 1'b0;
    end else begin
      occ   <= occ_next;
      ready <= (occ_next < 2'd2);
    end
  end

  // A push into a buffer that is emptying this cycle lands straight in head.
  always_ff @(posedge clk) begin
    if (pop_ok) begin
      if (occ == 2'd2)
        head_data <= tail_data;
      else if (push_ok)
        head_data <= push_data;
    end else if (push_ok) begin
      if (occ == 2'd0)
        head_data <= push_data;
      else
        tail_data <= push_data;
    end
  end

endmodule

// File: rtl/stream_fork2.sv
// Eager two-way fork: each input word is offered to branches A and B and
// retires from the skid buffer only once both have taken it.
module stream_fork2
  import stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [DATA_W-1:0] dout_a,
  output logic              valid_a,
  input  logic              ready_a,
  output logic [DATA_W-1:0] dout_b,
  output logic              valid_b,
  input  logic              ready_b
);

  logic              accept;
  logic              retire;
  logic              fire_a;
  logic              fire_b;
  logic              done_a;
  logic              done_b;
  logic              head_valid;
  logic [DATA_W-1:0] head_data;

  stream_skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (din),
    .ready     (ready_in),
    .pop       (retire),
    .head_data (head_data),
    .head_valid(head_valid)
  );

  assign accept  = valid_in & ready_in;
  assign dout_a  = head_data;
  assign dout_b  = head_data;
  assign valid_a = head_valid & ~done_a;
  assign valid_b = head_valid & ~done_b;
  assign fire_a  = valid_a & ready_a;
  assign fire_b  = valid_b & ready_b;
  assign retire  = head_valid & (done_a | fire_a) & (done_b | fire_b);

  // A branch that fires ahead of the other is masked until the word retires.
  always_ff @(posedge clk) begin
    if (rst || retire) begin
      done_a <= 1'b0;
      done_b <= 1'b0;
    end else begin
      if (fire_a) done_a <= 1'b1;
      if (fire_b) done_b <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_fork2.sv
// Randomized bench for stream_fork2 against a word-list reference model.
module tb_stream_fork2;
  import stream_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  data_t din;
  logic  valid_in;
  logic  ready_in;
  data_t dout_a;
  logic  valid_a;
  logic  ready_a;
  data_t dout_b;
  logic  valid_b;
  logic  ready_b;

  int    total = 0;
  int    bad = 0;

  // Model: every accepted word since reset, plus how many each branch has taken.
  data_t words[$];
  int    ca = 0;
  int    cb = 0;
  bit    post_rst = 1'b1;
  bit    last_acc;
  int    nextw = 1;

  always #5 clk = ~clk;

  stream_fork2 #(
    .DATA_W(DEFAULT_DATA_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .valid_in(valid_in),
    .ready_in(ready_in),
    .dout_a  (dout_a),
    .valid_a (valid_a),
    .ready_a (ready_a),
    .dout_b  (dout_b),
    .valid_b (valid_b),
    .ready_b (ready_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks outputs, advances the model across the edge.
  task automatic tick(input logic r, input logic v, input data_t d,
                      input logic ra, input logic rb);
    int    ret;
    logic  er, eva, evb;
    rst = r; valid_in = v; din = d; ready_a = ra; ready_b = rb;
    ret = (ca < cb) ? ca : cb;
    if (post_rst) begin
      er = 1'b0; eva = 1'b0; evb = 1'b0;
    end else begin
      er  = (words.size() - ret) < 2;
      eva = (words.size() > ret) && (ca == ret);
      evb = (words.size() > ret) && (cb == ret);
    end
    check("ready_in", {31'd0, ready_in}, {31'd0, er});
    check("valid_a", {31'd0, valid_a}, {31'd0, eva});
    check("valid_b", {31'd0, valid_b}, {31'd0, evb});
    if (eva) check("dout_a", {23'd0, dout_a}, {23'd0, words[ret]});
    if (evb) check("dout_b", {23'd0, dout_b}, {23'd0, words[ret]});
    last_acc = 1'b0;
    if (r) begin
      words.delete();
      ca = 0;
      cb = 0;
      post_rst = 1'b1;
    end else begin
      post_rst = 1'b0;
      if (eva && ra) ca++;
      if (evb && rb) cb++;
      if (v && er) begin
        words.push_back(d);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    data_t seq4[3];
    int    idx;
    int    cyc;
    rst = 1'b1; valid_in = 1'b1; din = '0; ready_a = 1'b0; ready_b = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with valid_in high.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, data_t'(9'h55), 1'b1, 1'b1);

    // Full-rate streaming.
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, data_t'(nextw), 1'b1, 1'b1);
      if (last_acc) nextw++;
    end
    drain(4);

    // Branch B stalls while A takes the word.
    tick(1'b0, 1'b1, data_t'(5), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Both branches stalled until the buffer is full, then released.
    seq4[0] = data_t'(7); seq4[1] = data_t'(8); seq4[2] = data_t'(9);
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, idx < 3, seq4[idx < 3 ? idx : 2], 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, idx < 3, seq4[idx < 3 ? idx : 2], 1'b1, 1'b1);
      if (last_acc) idx++;
    end
    check("bp_words_in", idx, 3);
    drain(3);

    // Random backpressure on both branches and random input gaps.
    nextw = 0;
    cyc = 0;
    while (nextw < 1000 && cyc < 20000) begin
      tick(1'b0, $urandom_range(0, 3) != 0, data_t'(nextw),
           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      if (last_acc) nextw++;
      cyc++;
    end
    check("rand_words_in", nextw, 1000);
    drain(6);
    check("rand_a_count", ca, words.size());
    check("rand_b_count", cb, words.size());

    // Fill to occupancy 2 with A ahead on the head, then reset.
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, data_t'(100 + i), 1'b1, 1'b0);
    end
    tick(1'b1, 1'b1, data_t'(9'h1ff), 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, data_t'(200 + i), 1'b1, 1'b1);
    drain(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
